pipe_rate_pm_ctrl: RTL and testbench

MAC-side sequencer for PIPE rate and power-state changes. It accepts one change request at a time from the LTSSM and drives `Rate`, `PowerDown`, `TxElecIdle` and `PclkChangeAck` on the PIPE interface. It completes the PHY handshake using `PclkChangeOk` and per-lane `PhyStatus`, with a timeout. It sits between the LTSSM and the PIPE MAC/PHY boundary, and is the only driver of those PIPE command signals.

---
 rtl/pipe_rate_pm_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_rate_pm_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rate_pm_ctrl.sv
// MAC-side sequencer for PIPE rate and power-state changes.
// Accepts one LTSSM request at a time, quiesces the transmitters, applies the
// new Rate/PowerDown, then completes the PCLK-change and per-lane PhyStatus
// handshake with the PHY, aborting on timeout.
module pipe_rate_pm_ctrl #(
  parameter int NUM_LANES      = 16,
  parameter int QUIESCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 PCLK,
  input  logic                 Reset,
  input  logic                 req_valid,
  input  logic [3:0]           req_rate,
  input  logic [3:0]           req_powerdown,
  output logic                 req_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  input  logic [NUM_LANES-1:0] PhyStatus,
  input  logic                 PclkChangeOk,
  output logic [3:0]           Rate,
  output logic [3:0]           PowerDown,
  output logic [NUM_LANES-1:0] TxElecIdle,
  output logic                 PclkChangeAck
);

  localparam int QW = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUIESCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    PD_P0  = 4'h0;
  localparam logic [3:0]    PD_P1  = 4'h2;

  typedef enum logic [2:0] {
    INIT, IDLE, QUIESCE, APPLY, WAIT_OK, WAIT_STATUS, DONE, ERR
  } state_t;

  state_t                 state;
  logic [QW-1:0]          quiesceCnt;
  logic [TW-1:0]          timeoutCnt;
  logic [NUM_LANES-1:0]   laneMask;
  logic [3:0]             latchRate;
  logic [3:0]             latchPowerDown;
  logic                   rateChange;

  logic [NUM_LANES-1:0]   maskNext;
  logic                   allLanesDone;
  logic                   timedOut;

  // Lane completion includes pulses arriving in the current cycle; the
  // timeout fires once the counter has reached its last allowed value.
  always_comb begin
    maskNext     = laneMask | PhyStatus;
    allLanesDone = &maskNext;
    timedOut     = (timeoutCnt >= T_LAST);
    req_ready    = (state == IDLE);
    busy         = (state != IDLE);
  end

  // Sequencer: single FSM with all PIPE outputs and status pulses registered.
  always_ff @(posedge PCLK) begin
    if (Reset) begin
      state          <= INIT;
      quiesceCnt     <= '0;
      timeoutCnt     <= '0;
      laneMask       <= '0;
      latchRate      <= 4'h0;
      latchPowerDown <= 4'h0;
      rateChange     <= 1'b0;
      Rate           <= 4'h0;
      PowerDown      <= PD_P1;
      TxElecIdle     <= '1;
      PclkChangeAck  <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        INIT: begin
          if (PhyStatus == '0) state <= IDLE;
        end
        IDLE: begin
          if (req_valid) begin
            latchRate      <= req_rate;
            latchPowerDown <= req_powerdown;
            rateChange     <= (req_rate != Rate);
            if ((req_rate == Rate) && (req_powerdown == PowerDown)) begin
              // No-op request completes immediately without touching the PHY.
              state      <= DONE;
              done       <= 1'b1;
              TxElecIdle <= (PowerDown == PD_P0) ? '0 : '1;
            end else begin
              state      <= QUIESCE;
              quiesceCnt <= '0;
              TxElecIdle <= '1;
            end
          end
        end
        QUIESCE: begin
          if (quiesceCnt == Q_LAST) begin
            state     <= APPLY;
            Rate      <= latchRate;
            PowerDown <= latchPowerDown;
          end else begin
            quiesceCnt <= quiesceCnt + 1'b1;
          end
        end
        APPLY: begin
          laneMask   <= '0;
          timeoutCnt <= '0;
          state      <= rateChange ? WAIT_OK : WAIT_STATUS;
        end
        WAIT_OK: begin
          laneMask   <= maskNext;
          timeoutCnt <= timeoutCnt + 1'b1;
          if (PclkChangeOk) begin
            PclkChangeAck <= 1'b1;
            state         <= WAIT_STATUS;
          end else if (timedOut) begin
            state         <= ERR;
            timeout_err   <= 1'b1;
            PclkChangeAck <= 1'b0;
            TxElecIdle    <= '1;
          end
        end
        WAIT_STATUS: begin
          laneMask   <= maskNext;
          timeoutCnt <= timeoutCnt + 1'b1;
          if (allLanesDone) begin
            state         <= DONE;
            done          <= 1'b1;
            PclkChangeAck <= 1'b0;
            TxElecIdle    <= (PowerDown == PD_P0) ? '0 : '1;
          end else if (timedOut) begin
            state         <= ERR;
            timeout_err   <= 1'b1;
            PclkChangeAck <= 1'b0;
            TxElecIdle    <= '1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_rate_pm_ctrl.sv
// Self-checking bench for pipe_rate_pm_ctrl (16 lanes, quiesce 4, timeout 16).
module tb_pipe_rate_pm_ctrl;

  localparam int NL = 16;

  logic          PCLK = 1'b0;
  logic          Reset;
  logic          req_valid;
  logic [3:0]    req_rate;
  logic [3:0]    req_powerdown;
  logic          req_ready;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [NL-1:0] PhyStatus;
  logic          PclkChangeOk;
  logic [3:0]    Rate;
  logic [3:0]    PowerDown;
  logic [NL-1:0] TxElecIdle;
  logic          PclkChangeAck;

  int tests = 0;
  int fails = 0;

  pipe_rate_pm_ctrl #(
    .NUM_LANES(NL),
    .QUIESCE_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK),
    .Reset(Reset),
    .req_valid(req_valid),
    .req_rate(req_rate),
    .req_powerdown(req_powerdown),
    .req_ready(req_ready),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .PhyStatus(PhyStatus),
    .PclkChangeOk(PclkChangeOk),
    .Rate(Rate),
    .PowerDown(PowerDown),
    .TxElecIdle(TxElecIdle),
    .PclkChangeAck(PclkChangeAck)
  );

  always #5 PCLK = ~PCLK;

  // One request scenario; cycle numbers are relative to the accept cycle T,
  // PHY event times are relative to APPLY (= T+5), -1 means never.
  typedef struct {
    string      name;
    logic [3:0] rate;
    logic [3:0] pd;
    int         okRel;
    int         loRel;
    int         hiRel;
    bit         busyReq;
    int         expDone;
    int         expErr;
    int         expAckFirst;
    int         expAckLast;
    logic [3:0] expRate;
    logic [3:0] expPd;
    bit         expTxIdle;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int doneAt, errAt, ackFirst, ackLast, readyAt, doneCnt, endCyc;
    logic [3:0] rateAtApply, pdAtApply;
    logic [NL-1:0] expTx;
    logic sawPulse;
    bit cleared;

    //        name        rate  pd    ok  lo  hi  busy done err ackF ackL rate  pd   txIdle
    vecs[0] = '{"pwr_only",  4'h0, 4'h0, -1,  3,  3, 0,  9, -1, -1, -1, 4'h0, 4'h0, 0};
    vecs[1] = '{"rate_stag", 4'h1, 4'h0,  5,  8, 12, 1, 18, -1, 11, 17, 4'h1, 4'h0, 0};
    vecs[2] = '{"noop",      4'h1, 4'h0, -1, -1, -1, 0,  1, -1, -1, -1, 4'h1, 4'h0, 0};
    vecs[3] = '{"mask_in_ok",4'h3, 4'h2,  3,  1,  4, 0, 10, -1,  9,  9, 4'h3, 4'h2, 1};
    vecs[4] = '{"timeout",   4'h2, 4'h0, -1, -1, -1, 0, -1, 22, -1, -1, 4'h2, 4'h0, 1};
    vecs[5] = '{"last_cyc",  4'h2, 4'h2, -1,  2, 16, 0, 22, -1, -1, -1, 4'h2, 4'h2, 1};
    vecs[6] = '{"to_after_ok",4'h4,4'h2,  2, -1, -1, 0, -1, 22,  8, 21, 4'h4, 4'h2, 1};

    // Reset / INIT: reset with all PhyStatus high, then release and clear.
    Reset = 1'b1; req_valid = 1'b0; req_rate = 4'h0; req_powerdown = 4'h0;
    PhyStatus = '1; PclkChangeOk = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_rate", Rate, 4'h0);
    chk("rst_pd", PowerDown, 4'h2);
    chk("rst_txidle", TxElecIdle, {NL{1'b1}});
    chk("rst_ack", PclkChangeAck, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", req_ready, 1'b0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("init_hold_ready", req_ready, 1'b0);
    end
    PhyStatus = '0;
    tick();
    chk("init_exit_ready", req_ready, 1'b1);
    chk("init_exit_busy", busy, 1'b0);

    // Table-driven request scenarios, each starting in IDLE.
    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      req_rate = v.rate; req_powerdown = v.pd; req_valid = 1'b1;
      doneAt = -1; errAt = -1; ackFirst = -1; ackLast = -1; readyAt = -1; doneCnt = 0;
      rateAtApply = 4'hx; pdAtApply = 4'hx;
      for (int c = 1; c <= 30; c++) begin
        tick();
        if (done) begin
          doneCnt++;
          if (doneAt < 0) doneAt = c;
        end
        if (timeout_err && errAt < 0) errAt = c;
        if (PclkChangeAck) begin
          if (ackFirst < 0) ackFirst = c;
          ackLast = c;
        end
        if (req_ready && readyAt < 0) readyAt = c;
        if (c == 5) begin
          rateAtApply = Rate;
          pdAtApply = PowerDown;
        end
        req_valid = 1'b0;
        if (v.busyReq && c == 2) begin
          req_valid = 1'b1; req_rate = 4'hF; req_powerdown = 4'hF;
        end
        PclkChangeOk = (v.okRel >= 0) && (c == 5 + v.okRel);
        PhyStatus = '0;
        if (v.loRel >= 0 && c == 5 + v.loRel) PhyStatus[7:0] = '1;
        if (v.hiRel >= 0 && c == 5 + v.hiRel) PhyStatus[15:8] = '1;
      end
      PhyStatus = '0; PclkChangeOk = 1'b0; req_valid = 1'b0;
      endCyc = (v.expDone >= 0) ? v.expDone : v.expErr;
      expTx = v.expTxIdle ? '1 : '0;
      chk({v.name, "_done_cyc"}, doneAt, v.expDone);
      chk({v.name, "_done_cnt"}, doneCnt, (v.expDone >= 0) ? 1 : 0);
      chk({v.name, "_err_cyc"}, errAt, v.expErr);
      chk({v.name, "_ack_first"}, ackFirst, v.expAckFirst);
      chk({v.name, "_ack_last"}, ackLast, v.expAckLast);
      chk({v.name, "_ready_cyc"}, readyAt, endCyc + 1);
      chk({v.name, "_rate_apply"}, rateAtApply, v.expRate);
      chk({v.name, "_pd_apply"}, pdAtApply, v.expPd);
      chk({v.name, "_rate_end"}, Rate, v.expRate);
      chk({v.name, "_pd_end"}, PowerDown, v.expPd);
      chk({v.name, "_txidle_end"}, TxElecIdle, expTx);
    end

    // Reset mid-operation: rate change, abort once in WAIT_STATUS with Ack high.
    sawPulse = 1'b0;
    req_rate = 4'h5; req_powerdown = 4'h2; req_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (done || timeout_err) sawPulse = 1'b1;
      req_valid = 1'b0;
      PclkChangeOk = (c == 6);
      PhyStatus = (c == 6) ? 16'h00FF : '0;
    end
    chk("mid_ack_before_rst", PclkChangeAck, 1'b1);
    chk("mid_rate_before_rst", Rate, 4'h5);
    PclkChangeOk = 1'b0; PhyStatus = '0;
    Reset = 1'b1;
    tick();
    if (done || timeout_err) sawPulse = 1'b1;
    chk("mid_rst_rate", Rate, 4'h0);
    chk("mid_rst_pd", PowerDown, 4'h2);
    chk("mid_rst_ack", PclkChangeAck, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b0);
    chk("mid_rst_txidle", TxElecIdle, {NL{1'b1}});
    Reset = 1'b0;
    PhyStatus = 16'hFF00;
    cleared = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done || timeout_err) sawPulse = 1'b1;
      PhyStatus = '0;
    end
    chk("mid_no_pulse", sawPulse, 1'b0);
    chk("mid_back_idle", req_ready, 1'b1);
    chk("mid_idle_pd", PowerDown, 4'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
